stage_mem: RTL
==============

# stage_mem

Memory-access stage of the 5-stage core, directly downstream of the execute stage. Takes the ALU result (effective address) and forwarded store operand produced in EX. Runs a request/grant/response transaction on the data-memory port, performs byte-lane steering and load sign/zero extension, and holds the pipeline with a stall until the access completes. The formatted load value feeds the MEM/WB register.

## Interface
- No parameters; data and address width is fixed at 32.
- Reset is synchronous and active-low. All state uses the rising edge of `clk`.
- `clk`  in  1  core clock; the only clock.
- `rstn`  in  1  synchronous, active-low reset.
- `me_alu_o`  in  32  effective address from EX.
- `me_regs_data2`  in  32  store data from EX, already forwarded.
- `me_func3_code`  in  3  access size/sign:
  - 000 = B, 001 = H, 010 = W
  - 100 = BU, 101 = HU
  - any other value is treated as W
- `me_mem_read`  in  1  load in MEM.
- `me_mem_write`  in  1  store in MEM. Never asserted together with `me_mem_read`.
- `dmem_req`  out  1  request valid (registered).
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word-aligned address, `{me_alu_o[31:2],2'b00}`.
- `dmem_wdata`  out  32  lane-steered store data.
- `dmem_be`  out  4  byte enables.
- `dmem_gnt`  in  1  memory accepted the request this cycle.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  32  read word.
- `me_mem_data`  out  32  formatted load result (registered).
- `mem_stall`  out  1  freeze PC/IF/ID/EX/MEM registers.
- `mem_misalign`  out  1  misaligned access flag, combinational.

## Operation
- `access` = `me_mem_read | me_mem_write`.
- Misalignment rules:
  - H/HU is misaligned when `addr[0]` = 1.
  - W is misaligned when `addr[1:0]` ≠ 0.
- `mem_misalign` = `access & misaligned`.
- A misaligned access is dropped: no request, no stall, `me_mem_data` is unchanged.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on an aligned access, go to REQ and register the dmem_* fields from the current inputs.
  - REQ: `dmem_req`=1. Hold every dmem_* field stable until `dmem_gnt`.
    - On grant: a store goes to DONE; a load goes to WAIT.
    - `dmem_req` drops in the cycle after grant.
  - WAIT: on `dmem_rvalid`, capture the formatted `dmem_rdata` into `me_mem_data` and go to DONE. An rvalid in the same cycle as gnt is not accepted; memory returns data at least 1 cycle after gnt.
  - DONE: one cycle. The pipeline advances. Next state is IDLE unconditionally.
- `mem_stall` = `access & ~mem_misalign & (state ≠ DONE)`. It is forced to 0 while `rstn` = 0.
- Store lane steering:
  - B: `wdata` = byte replicated ×4; `be` = `4'b0001 << addr[1:0]`.
  - H: `wdata` = half replicated ×2; `be` = `addr[1]` ? 1100 : 0011.
  - W: `be` = 1111.
- Load formatting: select byte `rdata[8*addr[1:0] +: 8]` or half `rdata[16*addr[1] +: 16]`.
  - B/H: sign-extend to 32.
  - BU/HU: zero-extend to 32.
  - W: pass through.
- For loads, `dmem_we`=0 and `be`=1111.

## Timing
- Reset values: state IDLE; `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be`, `me_mem_data` all 0; `mem_stall` 0.
- Store with immediate grant: cycle0 IDLE (stall=1), cycle1 REQ with gnt (stall=1), cycle2 DONE (stall=0). Two stall cycles in total.
- Load with gnt in cycle1 and rvalid in cycle2: cycle3 is DONE. Three stall cycles; `me_mem_data` is valid from cycle3 on.
- Each additional cycle without gnt or rvalid adds one stall cycle.
- Back-to-back memory instructions: after DONE the next instruction enters MEM and the FSM starts again from IDLE. There is one IDLE cycle per access.
- Reset mid-transaction: the FSM returns to IDLE and `dmem_req` is 0 in the following cycle. A late `dmem_rvalid` outside WAIT is ignored.
- EX inputs are stable while `mem_stall`=1. The block does not re-sample them in REQ or WAIT.

## Test plan
- SW: addr 0x100, data 0xDEADBEEF, gnt at first REQ cycle.
  - `dmem_addr`=0x100, `be`=1111, `we`=1.
  - stall high for exactly 2 cycles.
- SB: addr 0x103, data 0x000000A5.
  - `wdata`=0xA5A5A5A5, `be`=1000.
- LB / LBU / LH / LHU: `rdata`=0x80FF7F01.
  - LB @2 → 0xFFFFFFFF; LBU @2 → 0x000000FF.
  - LH @2 → 0xFFFF80FF; LHU @0 → 0x00007F01.
- LW: gnt delayed 3 cycles, rvalid 2 cycles after gnt.
  - stall high for 6 cycles.
  - `me_mem_data`=`rdata` in DONE.
  - `dmem_req`/`addr` stable throughout REQ.
- LW at addr 0x102: `mem_misalign`=1, `dmem_req` stays 0, `mem_stall`=0.
- `rstn` low during WAIT:
  - next cycle: state IDLE, `dmem_req`=0, `me_mem_data`=0.
  - an rvalid pulse then leaves `me_mem_data`=0.

Source files
------------

// File: rtl/stage_mem.sv
// Memory-access stage: runs one request/grant/response transaction per load or
// store, steers store lanes, formats load data and stalls the pipeline meanwhile.
module stage_mem (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] me_alu_o,
  input  logic [31:0] me_regs_data2,
  input  logic [2:0]  me_func3_code,
  input  logic        me_mem_read,
  input  logic        me_mem_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] me_mem_data,
  output logic        mem_stall,
  output logic        mem_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] data_q;
  logic [2:0]  fmt_q;
  logic [1:0]  off_q;

  logic access;
  logic misaligned;

  function automatic logic is_byte(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b100);
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

  function automatic logic [31:0] steer_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (is_byte(f3))      return {4{d[7:0]}};
    else if (is_half(f3)) return {2{d[15:0]}};
    else                  return d;
  endfunction

  function automatic logic [3:0] steer_be(input logic [2:0] f3, input logic [1:0] off);
    if (is_byte(f3))      return 4'b0001 << off;
    else if (is_half(f3)) return off[1] ? 4'b1100 : 4'b0011;
    else                  return 4'b1111;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = rd >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  assign access       = me_mem_read | me_mem_write;
  assign misaligned   = (is_half(me_func3_code) & me_alu_o[0]) |
                        (~is_byte(me_func3_code) & ~is_half(me_func3_code) & (me_alu_o[1:0] != 2'b00));
  assign mem_misalign = access & misaligned;
  // DONE is the single cycle in which the pipeline is released.
  assign mem_stall    = rstn & access & ~mem_misalign & (state_q != S_DONE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      data_q  <= 32'h0;
      fmt_q   <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access && !misaligned) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            we_q    <= me_mem_write;
            addr_q  <= {me_alu_o[31:2], 2'b00};
            wdata_q <= steer_wdata(me_func3_code, me_regs_data2);
            be_q    <= me_mem_write ? steer_be(me_func3_code, me_alu_o[1:0]) : 4'b1111;
            fmt_q   <= me_func3_code;
            off_q   <= me_alu_o[1:0];
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            req_q   <= 1'b0;
            state_q <= we_q ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            data_q  <= fmt_load(fmt_q, off_q, dmem_rdata);
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_be     = be_q;
  assign me_mem_data = data_q;

endmodule
